sim_ctrl_mon: RTL and testbench

//  Synthesizable simulation-control monitor. It snoops the SoC AHB-lite master port and decodes writes to a control address.

---
 rtl/sim_ctrl_pkg.sv | 32 +++
 rtl/sim_ctrl_char_fifo.sv | 65 ++++++
 rtl/sim_ctrl_mon.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sim_ctrl_mon.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sim_ctrl_pkg
//   Shared types and constants for the simulation-control monitor.
//   - result_e : completion codes reported on sim_ctrl_mon.result
//   - state_e  : run / drain / done phases of the monitor
//   - HTRANS_* : AHB-lite transfer types that carry a real transfer
// ----------------------------------------------------------------------------
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        RES_NONE = 3'd0,
        RES_PASS = 3'd1,
        RES_FAIL = 3'd2,
        RES_HANG = 3'd3,
        RES_MAXT = 3'd4
    } result_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // True for the two transfer types that start a real bus transfer.
    function automatic logic is_trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/sim_ctrl_char_fifo.sv
// ----------------------------------------------------------------------------
// sim_ctrl_char_fifo
//   Byte-wide first-word-fall-through FIFO for console characters.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (empties the FIFO)
//     push, din    write request and byte; ignored while full
//     pop          read request; ignored while empty
//     dout         head byte, valid whenever empty=0
//     full, empty  occupancy flags
//   A push while full is dropped even when a pop happens in the same cycle,
//   so bytes that made it in are never reordered behind a late arrival.
// ----------------------------------------------------------------------------
module sim_ctrl_char_fifo
    import sim_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sim_ctrl_mon.sv
// ----------------------------------------------------------------------------
// sim_ctrl_mon
//   Simulation-control monitor. Snoops an AHB-lite master port for writes to
//   CTRL_ADDR and turns them into PASS / FAIL results or console bytes, while
//   a per-channel retire watchdog and a run-time limit watch for HANG and
//   MAXTIME. After the first terminal event the console FIFO drains and done
//   rises; the result then holds until rst.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     htrans/haddr/hwrite/hready     AHB address-phase snoop
//     hwdata                         AHB write data (data phase)
//     retire[NUM_RETIRE]             per-channel instruction-retire pulse
//     retire_en[NUM_RETIRE]          channels covered by the watchdog
//     char_valid/char_data/char_ready console byte stream (FWFT)
//     char_ovf                       sticky, a console byte was dropped
//     done, result                   completion flag and code (result_e)
//     hang_chan                      channels that missed the failing window
//   Optional build macro SIM_CTRL_VTIMER_EN adds vtime_req / vtime: a
//   saturating 32-bit cycle counter snapshot taken on request.
// ----------------------------------------------------------------------------
module sim_ctrl_mon
    import sim_ctrl_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR  = 32'h6000fff8,
    parameter logic [31:0] PASS_LO    = 32'h00000fff,
    parameter logic [31:0] PASS_HI    = 32'hffff0000,
    parameter logic [31:0] FAIL_LO    = 32'h00000eee,
    parameter logic [31:0] FAIL_HI    = 32'heeee0000,
    parameter int          NUM_RETIRE = 1,
    parameter int          WINDOW     = 5000,
    parameter int          MAX_CYCLES = 70000000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            htrans,
    input  logic [31:0]           haddr,
    input  logic                  hwrite,
    input  logic                  hready,
    input  logic [31:0]           hwdata,
    input  logic [NUM_RETIRE-1:0] retire,
    input  logic [NUM_RETIRE-1:0] retire_en,
    output logic                  char_valid,
    output logic [7:0]            char_data,
    input  logic                  char_ready,
    output logic                  char_ovf,
    output logic                  done,
    output logic [2:0]            result,
    output logic [NUM_RETIRE-1:0] hang_chan
`ifdef SIM_CTRL_VTIMER_EN
    ,
    input  logic                  vtime_req,
    output logic [31:0]           vtime
`endif
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int RUN_W = $clog2(MAX_CYCLES);

    state_e                  state_reg;
    state_e                  state_next;
    logic                    in_run;

    logic                    pend_reg;
    logic                    pend_next;
    logic                    addr_phase;
    logic                    data_phase;
    logic                    is_pass_code;
    logic                    is_fail_code;
    logic                    dec_pass;
    logic                    dec_fail;
    logic                    dec_char;

    logic [WIN_W-1:0]        win_cnt_reg;
    logic [RUN_W-1:0]        run_cnt_reg;
    logic                    win_end;
    logic [NUM_RETIRE-1:0]   seen_reg;
    logic [NUM_RETIRE-1:0]   seen_next;
    logic [NUM_RETIRE-1:0]   miss;
    logic                    hang_evt;
    logic                    maxt_evt;
    logic                    term_evt;
    result_e                 evt_result;

    result_e                 result_reg;
    logic [NUM_RETIRE-1:0]   hang_chan_reg;
    logic                    char_ovf_reg;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [7:0]              fifo_dout;
    logic                    fifo_pop;

    assign in_run = (state_reg == ST_RUN);

    // ------------------------------------------------------------------
    // Bus snoop: an accepted address phase arms pend, the next hready
    // cycle is the data phase. Back-to-back writes re-arm in that cycle.
    // ------------------------------------------------------------------
    assign addr_phase = hready & hwrite & is_trans_active(htrans) &
                        (haddr == CTRL_ADDR);
    assign data_phase = hready & pend_reg;

    always_comb begin
        pend_next = pend_reg;
        if (addr_phase) begin
            pend_next = 1'b1;
        end else if (data_phase) begin
            pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign is_pass_code = (hwdata == PASS_LO) || (hwdata == PASS_HI);
    assign is_fail_code = (hwdata == FAIL_LO) || (hwdata == FAIL_HI);
    assign dec_pass     = in_run & data_phase & is_pass_code;
    assign dec_fail     = in_run & data_phase & is_fail_code;
    assign dec_char     = in_run & data_phase & ~is_pass_code & ~is_fail_code;

    // ------------------------------------------------------------------
    // Watchdog. A retire in the window's last cycle still counts, so the
    // miss test looks at seen and the live retire together.
    // ------------------------------------------------------------------
    assign win_end = (win_cnt_reg == WIN_W'(WINDOW - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RETIRE; gi++) begin : g_chan
            assign miss[gi]      = retire_en[gi] & ~(seen_reg[gi] | retire[gi]);
            assign seen_next[gi] = win_end ? 1'b0 : (seen_reg[gi] | retire[gi]);
        end
    endgenerate

    assign hang_evt = in_run & win_end & (|miss);
    assign maxt_evt = in_run & (run_cnt_reg == RUN_W'(MAX_CYCLES - 1));
    assign term_evt = dec_pass | dec_fail | hang_evt | maxt_evt;

    // Counters only advance in RUN; both stop before overflowing because
    // the terminal event moves the FSM out of RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_reg <= '0;
            run_cnt_reg <= '0;
            seen_reg    <= '0;
        end else if (in_run) begin
            win_cnt_reg <= win_end ? '0 : (win_cnt_reg + WIN_W'(1));
            run_cnt_reg <= run_cnt_reg + RUN_W'(1);
            seen_reg    <= seen_next;
        end
    end

    always_comb begin
        evt_result = RES_NONE;
        if (dec_pass) begin
            evt_result = RES_PASS;
        end else if (dec_fail) begin
            evt_result = RES_FAIL;
        end else if (hang_evt) begin
            evt_result = RES_HANG;
        end else if (maxt_evt) begin
            evt_result = RES_MAXT;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO. A char decoded in the same cycle as a terminal event
    // is still pushed; DRAIN then waits for it to be consumed.
    // ------------------------------------------------------------------
    assign fifo_pop = ~fifo_empty & char_ready;

    sim_ctrl_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dec_char),
        .din   (hwdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (term_evt)   state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_RUN;
        endcase
    end

    // Result and hang mask are captured only on the RUN->DRAIN transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg    <= RES_NONE;
            hang_chan_reg <= '0;
            char_ovf_reg  <= 1'b0;
        end else begin
            if (in_run && term_evt) begin
                result_reg    <= evt_result;
                hang_chan_reg <= (evt_result == RES_HANG) ? miss : '0;
            end
            if (dec_char && fifo_full) begin
                char_ovf_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        char_valid = ~fifo_empty;
        // Head byte is forced to zero while empty so reset leaves all outputs 0.
        char_data  = fifo_empty ? 8'h00 : fifo_dout;
        char_ovf   = char_ovf_reg;
        done       = (state_reg == ST_DONE);
        result     = result_reg;
        hang_chan  = hang_chan_reg;
    end

`ifdef SIM_CTRL_VTIMER_EN
    // ------------------------------------------------------------------
    // Virtual timer: free-running from reset, saturating, snapshot on req.
    // ------------------------------------------------------------------
    logic [31:0] vcnt_reg;
    logic [31:0] vtime_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt_reg  <= '0;
            vtime_reg <= '0;
        end else begin
            if (vcnt_reg != 32'hffffffff) begin
                vcnt_reg <= vcnt_reg + 32'd1;
            end
            if (vtime_req) begin
                vtime_reg <= vcnt_reg;
            end
        end
    end

    assign vtime = vtime_reg;
`endif

endmodule

// File: tb/tb_sim_ctrl_mon.sv
// ----------------------------------------------------------------------------
// tb_sim_ctrl_mon
//   Self-checking bench for sim_ctrl_mon. A transaction-level model (byte
//   queue, run-cycle count, window position from that count) predicts the
//   outputs every cycle; directed scenarios plus randomized bus traffic.
//   A second instance with a short run limit covers MAXTIME.
// ----------------------------------------------------------------------------
module tb_sim_ctrl_mon;
    import sim_ctrl_pkg::*;

    localparam logic [31:0] CTRL    = 32'h6000fff8;
    localparam logic [31:0] PASS_LO = 32'h00000fff;
    localparam logic [31:0] PASS_HI = 32'hffff0000;
    localparam logic [31:0] FAIL_LO = 32'h00000eee;
    localparam logic [31:0] FAIL_HI = 32'heeee0000;
    localparam int NR      = 2;
    localparam int WIN     = 8;
    localparam int MAXC    = 3000;
    localparam int MAXC_MT = 100;
    localparam int DEPTH   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    htrans = 2'b00;
    logic [31:0]   haddr = 32'h0;
    logic          hwrite = 1'b0;
    logic          hready = 1'b1;
    logic [31:0]   hwdata = 32'h0;
    logic [NR-1:0] retire = '0;
    logic [NR-1:0] retire_en = '0;
    logic          char_ready = 1'b0;

    logic          char_valid, char_ovf, done;
    logic [7:0]    char_data;
    logic [2:0]    result;
    logic [NR-1:0] hang_chan;

    logic          mt_char_valid, mt_char_ovf, mt_done;
    logic [7:0]    mt_char_data;
    logic [2:0]    mt_result;
    logic [NR-1:0] mt_hang_chan;

`ifdef SIM_CTRL_VTIMER_EN
    logic          vtime_req = 1'b0;
    logic [31:0]   vtime, mt_vtime;
`endif

    always #5 clk = ~clk;

    sim_ctrl_mon #(
        .NUM_RETIRE (NR), .WINDOW (WIN), .MAX_CYCLES (MAXC), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .htrans (htrans), .haddr (haddr),
        .hwrite (hwrite), .hready (hready), .hwdata (hwdata),
        .retire (retire), .retire_en (retire_en),
        .char_valid (char_valid), .char_data (char_data), .char_ready (char_ready),
        .char_ovf (char_ovf), .done (done), .result (result), .hang_chan (hang_chan)
`ifdef SIM_CTRL_VTIMER_EN
        , .vtime_req (vtime_req), .vtime (vtime)
`endif
    );

    sim_ctrl_mon #(
        .NUM_RETIRE (NR), .WINDOW (WIN), .MAX_CYCLES (MAXC_MT), .FIFO_DEPTH (DEPTH)
    ) dut_mt (
        .clk (clk), .rst (rst), .htrans (htrans), .haddr (haddr),
        .hwrite (hwrite), .hready (hready), .hwdata (hwdata),
        .retire (retire), .retire_en (retire_en),
        .char_valid (mt_char_valid), .char_data (mt_char_data), .char_ready (char_ready),
        .char_ovf (mt_char_ovf), .done (mt_done), .result (mt_result), .hang_chan (mt_hang_chan)
`ifdef SIM_CTRL_VTIMER_EN
        , .vtime_req (vtime_req), .vtime (mt_vtime)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state;   // 0 running, 1 draining, 2 done
    bit          m_pend;
    logic [7:0]  m_q[$];
    bit          m_ovf;
    int          m_res;
    logic [NR-1:0] m_hang;
    int          m_run;     // cycles spent running since reset
    logic [NR-1:0] m_seen;

    logic [7:0]  rx[$];     // bytes actually accepted from the DUT
    int          ret_mode = 0;
    int          cyc = 0;

    task automatic model_step();
        bit dp, ev, push, was_full, was_empty;
        int evres;
        logic [NR-1:0] miss;
        dp = 0; ev = 0; push = 0; evres = 0; miss = '0;
        if (rst) begin
            m_state = 0; m_pend = 0; m_q.delete(); m_ovf = 0; m_res = 0;
            m_hang = '0; m_run = 0; m_seen = '0;
            return;
        end
        dp = hready && m_pend;
        if (m_state == 0) begin
            if (dp) begin
                if (hwdata == PASS_LO || hwdata == PASS_HI) begin ev = 1; evres = 1; end
                else if (hwdata == FAIL_LO || hwdata == FAIL_HI) begin ev = 1; evres = 2; end
                else push = 1;
            end
            if ((m_run % WIN) == WIN - 1) begin
                miss = retire_en & ~(m_seen | retire);
                m_seen = '0;
                if (miss != '0 && !ev) begin ev = 1; evres = 3; end
            end else begin
                m_seen = m_seen | retire;
            end
            if (m_run == MAXC - 1 && !ev) begin ev = 1; evres = 4; end
            m_run++;
        end
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (!was_empty && char_ready) void'(m_q.pop_front());
        if (push) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back(hwdata[7:0]);
        end
        if (hready && hwrite && htrans[1] && haddr == CTRL) m_pend = 1;
        else if (dp) m_pend = 0;
        if (m_state == 0 && ev) begin
            m_state = 1; m_res = evres;
            m_hang = (evres == 3) ? miss : '0;
        end else if (m_state == 1 && was_empty) begin
            m_state = 2;
        end
    endtask

    task automatic compare_all();
        check("char_valid", 32'(char_valid), 32'(m_q.size() > 0));
        check("char_data",  32'(char_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        check("char_ovf",   32'(char_ovf),   32'(m_ovf));
        check("done",       32'(done),       32'(m_state == 2));
        check("result",     32'(result),     32'(m_res));
        check("hang_chan",  32'(hang_chan),  32'(m_hang));
    endtask

    task automatic tick();
        case (ret_mode)
            1:       retire = '1;
            2:       retire = ((cyc % 3) == 0) ? NR'(1) : NR'(0);
            3:       retire = NR'($urandom_range(0, 3)) & NR'($urandom_range(0, 3));
            default: retire = '0;
        endcase
        if (!rst && char_valid && char_ready) rx.push_back(char_data);
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle();
        htrans = 2'b00; hwrite = 1'b0; hready = 1'b1;
        tick();
    endtask

    task automatic ahb_write(input logic [31:0] data);
        $display("write 0x%08h to ctrl", data);
        htrans = HTRANS_NONSEQ; haddr = CTRL; hwrite = 1'b1; hready = 1'b1;
        tick();
        htrans = 2'b00; hwrite = 1'b0; hwdata = data;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; htrans = 2'b00; hwrite = 1'b0; hready = 1'b1;
        char_ready = 1'b0; retire_en = '0; ret_mode = 0;
        tick();
        rst = 1'b0;
        cyc = 0;
        rx.delete();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            idle();
            n++;
        end
        check("wait_done", 32'(done), 32'd1);
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(char_valid), 32'd0);
        check("rst_mt_result", 32'(mt_result), 32'd0);

        // "Hi" then PASS
        char_ready = 1'b1;
        ahb_write(32'h48); ahb_write(32'h69); ahb_write(PASS_LO);
        wait_done(50);
        check("hi_count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            check("hi_byte0", 32'(rx[0]), 32'h48);
            check("hi_byte1", 32'(rx[1]), 32'h69);
        end
        check("hi_result", 32'(result), 32'd1);

        // FAIL with 3 bytes queued, consumer stalled
        do_reset();
        ahb_write(32'h41); ahb_write(32'h42); ahb_write(32'h43); ahb_write(FAIL_HI);
        for (int i = 0; i < 20; i++) idle();
        check("fail_stall_done", 32'(done), 32'd0);
        check("fail_stall_valid", 32'(char_valid), 32'd1);
        char_ready = 1'b1;
        wait_done(50);
        check("fail_count", 32'(rx.size()), 32'd3);
        for (int i = 0; i < 3 && i < rx.size(); i++)
            check("fail_byte", 32'(rx[i]), 32'h41 + 32'(i));
        check("fail_result", 32'(result), 32'd2);

        // watchdog: channel 1 never retires
        do_reset();
        retire_en = 2'b11; ret_mode = 2;
        for (int i = 0; i < 8; i++) idle();
        check("hang_result", 32'(result), 32'd3);
        check("hang_chan", 32'(hang_chan), 32'h2);
        wait_done(10);
        // channel 1 disabled: no hang
        do_reset();
        retire_en = 2'b01; ret_mode = 2;
        for (int i = 0; i < 40; i++) idle();
        check("nohang_result", 32'(result), 32'd0);
        check("nohang_done", 32'(done), 32'd0);

        // run limit on the short instance
        do_reset();
        retire_en = 2'b11; ret_mode = 1;
        for (int i = 0; i < 100; i++) idle();
        check("maxt_result", 32'(mt_result), 32'd4);
        check("maxt_done_early", 32'(mt_done), 32'd0);
        idle();
        check("maxt_done", 32'(mt_done), 32'd1);
        check("maxt_hang", 32'(mt_hang_chan), 32'd0);

        // overflow: 6 bytes into a 4-deep FIFO
        do_reset();
        for (int i = 0; i < 6; i++) ahb_write(32'h30 + 32'(i));
        idle();
        check("ovf_flag", 32'(char_ovf), 32'd1);
        char_ready = 1'b1;
        for (int i = 0; i < 8; i++) idle();
        check("ovf_count", 32'(rx.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx.size(); i++)
            check("ovf_byte", 32'(rx[i]), 32'h30 + 32'(i));

        // PASS data phase on the same cycle as a hanging window end
        do_reset();
        retire_en = 2'b11; ret_mode = 0; char_ready = 1'b1;
        while (m_run < WIN - 2) idle();
        ahb_write(PASS_HI);
        wait_done(10);
        check("prio_result", 32'(result), 32'd1);
        check("prio_hang", 32'(hang_chan), 32'd0);

        // reset while draining
        do_reset();
        ahb_write(32'h55); ahb_write(32'h66); ahb_write(PASS_LO);
        for (int i = 0; i < 3; i++) idle();
        check("drain_done", 32'(done), 32'd0);
        check("drain_result", 32'(result), 32'd1);
        do_reset();
        check("rstd_valid", 32'(char_valid), 32'd0);
        check("rstd_data", 32'(char_data), 32'd0);
        check("rstd_result", 32'(result), 32'd0);
        check("rstd_done", 32'(done), 32'd0);

        // randomized bus traffic
        for (int run = 0; run < 8; run++) begin
            int n;
            do_reset();
            retire_en = NR'($urandom_range(0, 3));
            ret_mode = 3;
            n = 0;
            while (!done && n < 300) begin
                htrans = 2'($urandom_range(0, 3));
                haddr  = ($urandom_range(0, 1) == 1) ? CTRL : $urandom();
                hwrite = 1'($urandom_range(0, 1));
                hready = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 59))
                    0:       hwdata = PASS_LO;
                    1:       hwdata = PASS_HI;
                    2:       hwdata = FAIL_LO;
                    3:       hwdata = FAIL_HI;
                    default: hwdata = {$urandom_range(0, 1) == 1 ? 24'h0 : 24'($urandom()), 8'($urandom())};
                endcase
                char_ready = ($urandom_range(0, 2) != 0);
                tick();
                n++;
            end
            $display("random run %0d: %0d cycles, result %0d, %0d bytes consumed", run, n, result, rx.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
